// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage that bridges EX to a single-outstanding data bus and retires into WB.
//   clk, rst (async, active-high)
//   EX side : ex_valid, ALUout, store_data, MemRd, MemWr, MemSize, MemSign, RWSel, rd, RegWr -> mem_stall
//   Bus side: bus_req, bus_we, bus_addr, bus_wdata, bus_be <- bus_ack, bus_rdata
//   WB side : wb_valid, wb_ALUout, wb_RAMdata, wb_RWSel, wb_rd, wb_RegWr, misalign, bus_err
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ALUout,
    input  logic [15:0] store_data,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        MemSize,
    input  logic        MemSign,
    input  logic [1:0]  RWSel,
    input  logic [3:0]  rd,
    input  logic        RegWr,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic [1:0]  bus_be,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_ALUout,
    output logic [15:0] wb_RAMdata,
    output logic [1:0]  wb_RWSel,
    output logic [3:0]  wb_rd,
    output logic        wb_RegWr,
    output logic        misalign,
    output logic        bus_err
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    logic        size_q, sign_q, lane_q, regwr_q;
    logic [15:0] alu_q;
    logic [1:0]  rwsel_q;
    logic [3:0]  rd_q;
    logic mem_op, mis, accept, expire;
    logic [7:0]  lane;
    logic [15:0] load_data;
    always_comb begin
        mem_op    = MemRd | MemWr;
        mis       = mem_op & MemSize & ALUout[0];
        // rst gating keeps mem_stall low during reset even if EX still drives a request
        accept    = (state == IDLE) & ex_valid & mem_op & ~mis & ~rst;
        expire    = cnt == 8'(TIMEOUT - 1);
        mem_stall = (state == WAIT) | accept;
        bus_req   = state == WAIT;
        lane      = lane_q ? bus_rdata[15:8] : bus_rdata[7:0];
        load_data = size_q ? bus_rdata : {{8{sign_q & lane[7]}}, lane};
        state_nx  = state;
        if (state == IDLE)
            state_nx = accept ? WAIT : IDLE;
        else
            state_nx = (bus_ack | expire) ? IDLE : WAIT;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            size_q     <= 1'b0;
            sign_q     <= 1'b0;
            lane_q     <= 1'b0;
            regwr_q    <= 1'b0;
            alu_q      <= '0;
            rwsel_q    <= '0;
            rd_q       <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            wb_valid   <= 1'b0;
            wb_ALUout  <= '0;
            wb_RAMdata <= '0;
            wb_RWSel   <= '0;
            wb_rd      <= '0;
            wb_RegWr   <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    cnt       <= '0;
                    size_q    <= MemSize;
                    sign_q    <= MemSign;
                    lane_q    <= ALUout[0];
                    regwr_q   <= RegWr & ~MemWr;
                    alu_q     <= ALUout;
                    rwsel_q   <= RWSel;
                    rd_q      <= rd;
                    bus_we    <= MemWr;
                    bus_addr  <= {ALUout[15:1], 1'b0};
                    bus_wdata <= MemSize ? store_data : {2{store_data[7:0]}};
                    bus_be    <= MemSize ? 2'b11 : (ALUout[0] ? 2'b10 : 2'b01);
                end else if (ex_valid) begin
                    wb_valid  <= 1'b1;
                    misalign  <= mis;
                    wb_ALUout <= ALUout;
                    wb_RWSel  <= RWSel;
                    wb_rd     <= rd;
                    wb_RegWr  <= RegWr & ~mis;
                end
            end else if (bus_ack | expire) begin
                wb_valid  <= 1'b1;
                bus_err   <= ~bus_ack;
                wb_ALUout <= alu_q;
                wb_RWSel  <= rwsel_q;
                wb_rd     <= rd_q;
                wb_RegWr  <= regwr_q & bus_ack;
                if (bus_ack & ~bus_we) wb_RAMdata <= load_data;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven and randomized self-checking bench for mem_stage.
module tb_mem_stage;
    localparam int TO = 4;
    logic clk = 0, rst = 1;
    logic ex_valid = 0, MemRd = 0, MemWr = 0, MemSize = 0, MemSign = 0, RegWr = 0, bus_ack = 0;
    logic [15:0] ALUout = 0, store_data = 0, bus_rdata = 0;
    logic [1:0] RWSel = 0;
    logic [3:0] rd = 0;
    logic mem_stall, bus_req, bus_we, wb_valid, wb_RegWr, misalign, bus_err;
    logic [15:0] bus_addr, bus_wdata, wb_ALUout, wb_RAMdata;
    logic [1:0] bus_be, wb_RWSel;
    logic [3:0] wb_rd;
    int nchk = 0, nfail = 0;
    logic [15:0] last_ram = 0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ALUout(ALUout), .store_data(store_data),
        .MemRd(MemRd), .MemWr(MemWr), .MemSize(MemSize), .MemSign(MemSign), .RWSel(RWSel),
        .rd(rd), .RegWr(RegWr), .mem_stall(mem_stall), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .wb_valid(wb_valid), .wb_ALUout(wb_ALUout), .wb_RAMdata(wb_RAMdata),
        .wb_RWSel(wb_RWSel), .wb_rd(wb_rd), .wb_RegWr(wb_RegWr), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alu, sd;
        logic mrd, mwr, sz, sg;
        logic [1:0] rws;
        logic [3:0] rdn;
        logic rw;
        int d;
        logic [15:0] rdata;
        logic upd;
        logic [15:0] ram;
        logic regwr, mis, err;
        logic [1:0] be;
        logic [15:0] addr, wdata;
        logic we;
        int nbus;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic vec_t mk(logic [15:0] alu, logic [15:0] sd, logic mrd, logic mwr, logic sz, logic sg,
                                logic [1:0] rws, logic [3:0] rdn, logic rw, int d, logic [15:0] rdata,
                                logic upd, logic [15:0] ram, logic regwr, logic mis, logic err,
                                logic [1:0] be, logic [15:0] addr, logic [15:0] wdata, logic we, int nbus);
        vec_t v;
        v.alu = alu; v.sd = sd; v.mrd = mrd; v.mwr = mwr; v.sz = sz; v.sg = sg; v.rws = rws; v.rdn = rdn;
        v.rw = rw; v.d = d; v.rdata = rdata; v.upd = upd; v.ram = ram; v.regwr = regwr; v.mis = mis;
        v.err = err; v.be = be; v.addr = addr; v.wdata = wdata; v.we = we; v.nbus = nbus;
        return v;
    endfunction

    // Transaction-level reference: what one instruction must look like at the WB and bus boundaries.
    function automatic vec_t model(vec_t v);
        bit mem = v.mrd | v.mwr;
        bit mis = mem & v.sz & v.alu[0];
        bit go = mem & !mis;
        bit to = go && v.d >= TO;
        logic [7:0] b = v.alu[0] ? v.rdata[15:8] : v.rdata[7:0];
        v.mis = mis;
        v.err = to;
        v.nbus = go ? (to ? TO : v.d + 1) : 0;
        v.regwr = v.rw && !mis && !to && !v.mwr;
        v.upd = go && !to && !v.mwr;
        v.ram = v.sz ? v.rdata : (v.sg ? 16'($signed(b)) : {8'h00, b});
        v.be = v.sz ? 2'b11 : (v.alu[0] ? 2'b10 : 2'b01);
        v.addr = v.alu & 16'hFFFE;
        v.wdata = v.sz ? v.sd : {v.sd[7:0], v.sd[7:0]};
        v.we = v.mwr;
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int stall = 0, seen = 0;
        bit got = 0;
        @(negedge clk);
        ex_valid = 1; ALUout = v.alu; store_data = v.sd; MemRd = v.mrd; MemWr = v.mwr;
        MemSize = v.sz; MemSign = v.sg; RWSel = v.rws; rd = v.rdn; RegWr = v.rw;
        bus_rdata = v.rdata; bus_ack = 0;
        #1;
        for (int c = 0; c < 20 && !got; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (mem_stall) stall++;
            if (bus_req) begin
                if (seen == 0) begin
                    chk({tag, " bus_addr"}, bus_addr, v.addr);
                    chk({tag, " bus_be"}, bus_be, v.be);
                    chk({tag, " bus_we"}, bus_we, v.we);
                    if (v.we) chk({tag, " bus_wdata"}, bus_wdata, v.wdata);
                end
                bus_ack = (seen >= v.d);
                seen++;
            end else bus_ack = 0;
            @(posedge clk); #1;
            got = wb_valid;
        end
        ex_valid = 0; bus_ack = 0;
        if (v.upd) last_ram = v.ram;
        chk({tag, " retire"}, got, 1);
        chk({tag, " misalign"}, misalign, v.mis);
        chk({tag, " bus_err"}, bus_err, v.err);
        chk({tag, " wb_RegWr"}, wb_RegWr, v.regwr);
        chk({tag, " wb_ALUout"}, wb_ALUout, v.alu);
        chk({tag, " wb_rd"}, wb_rd, v.rdn);
        chk({tag, " wb_RWSel"}, wb_RWSel, v.rws);
        chk({tag, " wb_RAMdata"}, wb_RAMdata, last_ram);
        chk({tag, " stall_cycles"}, stall, v.nbus ? v.nbus + 1 : 0);
        chk({tag, " bus_cycles"}, seen, v.nbus);
        @(posedge clk); #1;
        chk({tag, " single_pulse"}, wb_valid, 0);
        chk({tag, " idle_req"}, bus_req, 0);
        chk({tag, " idle_stall"}, mem_stall, 0);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        //          alu      sd       rd wr sz sg rws rdn  rw d   rdata     upd ram      rgw mis err be     addr     wdata    we nbus
        tbl[0] = mk(16'h1234, 16'h0, 0, 0, 0, 0, 2, 4'd3, 1, 0, 16'h0,    0, 16'h0,    1, 0, 0, 2'b00, 16'h0,   16'h0,   0, 0);
        tbl[1] = mk(16'h0011, 16'h0, 1, 0, 0, 1, 1, 4'd5, 1, 2, 16'h80AA, 1, 16'hFF80, 1, 0, 0, 2'b10, 16'h0010, 16'h0,   0, 3);
        tbl[2] = mk(16'h0020, 16'hC5, 0, 1, 0, 0, 0, 4'd6, 1, 0, 16'h0,   0, 16'h0,    0, 0, 0, 2'b01, 16'h0020, 16'hC5C5, 1, 1);
        tbl[3] = mk(16'h0003, 16'h0, 1, 0, 1, 0, 1, 4'd7, 1, 0, 16'h0,    0, 16'h0,    0, 1, 0, 2'b00, 16'h0,   16'h0,   0, 0);
        tbl[4] = mk(16'h0040, 16'h0, 1, 0, 1, 0, 1, 4'd8, 1, 10, 16'h1111, 0, 16'h0,   0, 0, 1, 2'b11, 16'h0040, 16'h0,   0, 4);
        tbl[5] = mk(16'h0011, 16'h0, 1, 0, 0, 0, 1, 4'd9, 1, 0, 16'h80AA, 1, 16'h0080, 1, 0, 0, 2'b10, 16'h0010, 16'h0,   0, 1);
        tbl[6] = mk(16'h0100, 16'hBEEF, 1, 1, 1, 0, 0, 4'd2, 1, 1, 16'h0, 0, 16'h0,    0, 0, 0, 2'b11, 16'h0100, 16'hBEEF, 1, 2);
        tbl[7] = mk(16'h0202, 16'h0, 1, 0, 1, 0, 1, 4'd4, 1, 3, 16'h1357, 1, 16'h1357, 1, 0, 0, 2'b11, 16'h0202, 16'h0,   0, 4);
        tbl[8] = mk(16'h0030, 16'h0, 1, 0, 0, 1, 1, 4'd1, 0, 1, 16'h12F0, 1, 16'hFFF0, 0, 0, 0, 2'b01, 16'h0030, 16'h0,   0, 2);

        #2;
        chk("reset bus_req", bus_req, 0);
        chk("reset mem_stall", mem_stall, 0);
        chk("reset wb_valid", wb_valid, 0);
        chk("reset wb_ALUout", wb_ALUout, 0);
        chk("reset wb_RAMdata", wb_RAMdata, 0);
        chk("reset faults", {misalign, bus_err, wb_RegWr}, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("vec%0d", i));

        // reset while a bus cycle is outstanding, then a stray ack afterwards
        @(negedge clk);
        ex_valid = 1; ALUout = 16'h0050; MemRd = 1; MemWr = 0; MemSize = 1; bus_ack = 0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_wait bus_req_before", bus_req, 1);
        #2 rst = 1;
        #1;
        chk("rst_wait bus_req", bus_req, 0);
        chk("rst_wait mem_stall", mem_stall, 0);
        chk("rst_wait wb_valid", wb_valid, 0);
        ex_valid = 0;
        @(negedge clk);
        rst = 0; bus_ack = 1;
        last_ram = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_wait stray_ack_valid", wb_valid, 0);
            chk("rst_wait stray_ack_req", bus_req, 0);
        end
        bus_ack = 0;
        run(tbl[0], "post_rst_alu");

        for (int i = 0; i < 60; i++) begin
            rv.alu = 16'($urandom);
            rv.sd = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin rv.mrd = 0; rv.mwr = 0; end
                1: begin rv.mrd = 1; rv.mwr = 0; end
                2: begin rv.mrd = 0; rv.mwr = 1; end
                default: begin rv.mrd = 1; rv.mwr = 1; end
            endcase
            rv.sz = 1'($urandom); rv.sg = 1'($urandom); rv.rws = 2'($urandom);
            rv.rdn = 4'($urandom); rv.rw = 1'($urandom);
            rv.d = $urandom_range(0, 6); rv.rdata = 16'($urandom);
            run(model(rv), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum bus wait cycles before abort; legal range 1..255.
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  EX stage presents an instruction this cycle.
REQ-005 ALUout  in  16  ALU result; byte address for memory ops.
REQ-006 store_data  in  16  store operand, right-aligned.
REQ-007 MemRd / MemWr  in  1 each  load / store request.
REQ-008 MemSize  in  1  0 = byte, 1 = halfword.
REQ-009 MemSign  in  1  1 = sign-extend byte loads, 0 = zero-extend.
REQ-010 RWSel  in  2  write-back source select, passed through.
REQ-011 rd  in  4  destination register; RegWr  in  1  register write enable.
REQ-012 mem_stall  out  1  holds EX/upstream stages; inputs held stable while high.
REQ-013 bus_req, bus_we  out  1 each  data-bus request and write strobe.
REQ-014 bus_addr  out  16  halfword-aligned address ({ALUout[15:1],1'b0}).
REQ-015 bus_wdata  out  16; bus_be  out  2  byte enables (bit0 = low byte).
REQ-016 bus_ack  in  1; bus_rdata  in  16  completion strobe and read data.
REQ-017 wb_valid  out  1  one-cycle pulse per retired instruction.
REQ-018 wb_ALUout, wb_RAMdata  out  16 each; wb_RWSel  out  2; wb_rd  out  4; wb_RegWr  out  1.
REQ-019 misalign, bus_err  out  1 each  one-cycle fault pulses.

Function
REQ-020 FSM states: IDLE, WAIT.
REQ-021 IDLE, ex_valid, no memory op: wb_* load inputs at the next edge; wb_valid = 1 for that cycle; mem_stall = 0.
REQ-022 IDLE, ex_valid, memory op, aligned: latch address/data/control; enter WAIT; mem_stall = 1 combinationally in the acceptance cycle.
REQ-023 MemRd and MemWr both high: treat as store; RegWr forced 0.
REQ-024 Halfword op with ALUout[0] = 1: no bus cycle; misalign pulses and wb_valid pulses at the next edge; wb_RegWr = 0; remain in IDLE; mem_stall = 0.
REQ-025 WAIT: bus_req = 1 and mem_stall = 1; bus_addr/bus_we/bus_wdata/bus_be stable from latched values.
REQ-026 Byte lanes: halfword -> be = 11; byte at even address -> be = 01; byte at odd address -> be = 10; store byte replicated on both lanes of bus_wdata.
REQ-027 bus_ack high in WAIT (including the first WAIT cycle): at that edge, register the formatted read data into wb_RAMdata, pulse wb_valid, return to IDLE; bus_req and mem_stall deassert in the following cycle.
REQ-028 Load formatting: halfword -> bus_rdata; byte -> selected lane, extended per MemSign to 16 bits; stores leave wb_RAMdata unchanged.
REQ-029 bus_ack in IDLE is ignored.
REQ-030 8-bit wait counter clears on WAIT entry and increments each WAIT cycle without ack.
REQ-031 Counter reaches TIMEOUT with no ack: abort to IDLE; pulse bus_err and wb_valid; wb_RegWr = 0.
REQ-032 Ack on the same edge as timeout: ack wins; no bus_err.
REQ-033 wb_* outputs other than wb_valid hold their values between updates.
REQ-034 Exactly one wb_valid pulse per accepted instruction.

Reset
REQ-035 On rst (asynchronous, mid-transaction included): state = IDLE, counter = 0; all outputs 0 (bus_req, mem_stall, wb_valid, misalign, bus_err, wb_* data).
REQ-036 After rst release: first rising edge with ex_valid is accepted normally.

Verification
REQ-037 ALU op (RegWr = 1, rd = 3, ALUout = 0x1234): next cycle wb_valid = 1, wb_ALUout = 0x1234, wb_rd = 3, no bus_req.
REQ-038 Signed byte load @0x0011 (MemSign = 1): be = 10, addr = 0x0010, ack after 3 cycles with rdata = 0x80AA -> wb_RAMdata = 0xFF80; mem_stall high 4 cycles.
REQ-039 Byte store 0x00C5 @0x0020: be = 01, wdata = 0xC5C5, bus_we = 1, wb_RegWr = 0.
REQ-040 Halfword load @0x0003: misalign pulse, no bus_req, wb_RegWr = 0.
REQ-041 TIMEOUT = 4, no ack: bus_req drops after 4 WAIT cycles; bus_err and wb_valid pulse together.
REQ-042 rst asserted in WAIT: bus_req and mem_stall fall immediately; a later ack is ignored.
